// File: rtl/plab2_proc_muldiv_iterative.sv
// Iterative 32-bit multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle over 32 cycles, with val/rdy request and response handshakes.
module plab2_proc_muldiv_iterative #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               domain,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [2:0]         req_fn,
  input  logic [p_nbits-1:0] req_a,
  input  logic [p_nbits-1:0] req_b,
  input  logic               kill,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [p_nbits-1:0] resp_result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  state_t              state_reg, state_next;
  logic [5:0]          cnt_reg;
  logic [2:0]          fn_reg;
  logic [p_nbits-1:0]  a_reg, b_reg, acc_reg, result_reg;
  logic                neg_q_reg, neg_r_reg, dz_reg, ovf_reg, domain_reg;

  logic                accept, calc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req_rdy    = 1'b0;
    resp_val   = 1'b0;
    accept     = 1'b0;
    calc       = 1'b0;
    case (state_reg)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_val) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        calc = !kill;
        if (kill)              state_next = IDLE;
        else if (cnt_reg == 6'd1) state_next = DONE;
      end
      DONE: begin
        resp_val = 1'b1;
        if (kill || resp_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Accept-time decode: magnitudes and sign flags apply only to the signed divide ops
  logic               signed_op, a_neg, b_neg;
  logic [p_nbits-1:0] a_mag, b_mag;

  always_comb begin
    signed_op = (req_fn == FN_DIV) || (req_fn == FN_REM);
    a_neg     = signed_op && req_a[p_nbits-1];
    b_neg     = signed_op && req_b[p_nbits-1];
    a_mag     = a_neg ? -req_a : req_a;
    b_mag     = b_neg ? -req_b : req_b;
  end

  // One iteration step; a_reg doubles as the quotient shift register during divide
  logic [p_nbits:0]   rem_sh, diff;
  logic               q_bit;
  logic [p_nbits-1:0] a_iter, b_iter, acc_iter, quot, rem, result_calc;

  always_comb begin
    rem_sh   = {acc_reg, a_reg[p_nbits-1]};
    diff     = rem_sh - {1'b0, b_reg};
    q_bit    = !diff[p_nbits];
    a_iter   = a_reg;
    b_iter   = b_reg;
    acc_iter = acc_reg;
    if (fn_reg == FN_MUL) begin
      acc_iter = acc_reg + (b_reg[0] ? a_reg : '0);
      a_iter   = a_reg << 1;
      b_iter   = b_reg >> 1;
    end else begin
      acc_iter = q_bit ? diff[p_nbits-1:0] : rem_sh[p_nbits-1:0];
      a_iter   = {a_reg[p_nbits-2:0], q_bit};
    end
    quot = neg_q_reg ? -a_iter : a_iter;
    rem  = neg_r_reg ? -acc_iter : acc_iter;
    // Zero-divisor remainders fall out of the arithmetic as the dividend itself
    case (fn_reg)
      FN_MUL:  result_calc = acc_iter;
      FN_DIV:  result_calc = dz_reg ? '1 : (ovf_reg ? {1'b1, {(p_nbits-1){1'b0}}} : quot);
      FN_DIVU: result_calc = dz_reg ? '1 : a_iter;
      FN_REM:  result_calc = ovf_reg ? '0 : rem;
      FN_REMU: result_calc = acc_iter;
      default: result_calc = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg    <= '0;
      fn_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      dz_reg     <= 1'b0;
      ovf_reg    <= 1'b0;
      domain_reg <= 1'b0;
    end else if (accept) begin
      cnt_reg    <= 6'd32;
      fn_reg     <= req_fn;
      a_reg      <= a_mag;
      b_reg      <= b_mag;
      acc_reg    <= '0;
      neg_q_reg  <= a_neg ^ b_neg;
      neg_r_reg  <= a_neg;
      dz_reg     <= (req_b == '0);
      ovf_reg    <= signed_op && (req_a == {1'b1, {(p_nbits-1){1'b0}}}) && (req_b == '1);
      domain_reg <= domain;
    end else if (calc) begin
      cnt_reg <= cnt_reg - 6'd1;
      a_reg   <= a_iter;
      b_reg   <= b_iter;
      acc_reg <= acc_iter;
      if (cnt_reg == 6'd1) result_reg <= result_calc;
    end
  end

  assign resp_result = result_reg;

  // The security domain of an operation may not change while it is in flight
  assert property (@(posedge clk) disable iff (!reset)
                   (state_reg != IDLE) |-> (domain == domain_reg));

endmodule

// File: tb/tb_plab2_proc_muldiv_iterative.sv
// Self-checking bench for the iterative mul/div unit: directed cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_plab2_proc_muldiv_iterative;

  logic        clk = 1'b0;
  logic        reset;
  logic        domain;
  logic        req_val;
  logic        req_rdy;
  logic [2:0]  req_fn;
  logic [31:0] req_a, req_b;
  logic        kill;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  plab2_proc_muldiv_iterative #(.p_nbits(32)) dut (
    .clk(clk), .reset(reset), .domain(domain),
    .req_val(req_val), .req_rdy(req_rdy), .req_fn(req_fn),
    .req_a(req_a), .req_b(req_b), .kill(kill),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_result(resp_result)
  );

  // domain must stay put from request accept until the unit is idle again
  logic dom_q = 1'b0;
  always @(posedge clk) begin
    if (reset && req_val && req_rdy) dom_q <= domain;
    else if (reset && !req_rdy)
      assert (domain == dom_q) else $error("domain changed while busy");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] fn, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (fn)
      3'd0: return 32'(a * b);
      3'd1: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd3: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      3'd4: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic start_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    domain = 1'($urandom);
    check("idle_rdy", 32'(req_rdy), 32'd1);
    req_val = 1'b1; req_fn = fn; req_a = a; req_b = b;
    @(negedge clk);
    req_val = 1'b0; kill = 1'b0;
    req_fn = 3'($urandom); req_a = $urandom; req_b = $urandom;
    check("busy_rdy", 32'(req_rdy), 32'd0);
  endtask

  // Counts cycles from accept (1 = cycle right after the accept edge); bounded
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_val && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int hold);
    int lat;
    logic [31:0] held;
    start_op(fn, a, b);
    wait_resp(lat);
    check({tag, "_lat"}, 32'(lat), 32'd33);
    check({tag, "_res"}, resp_result, exp);
    held = resp_result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_val"}, 32'(resp_val), 32'd1);
      check({tag, "_hold_res"}, resp_result, held);
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    check({tag, "_val_drop"}, 32'(resp_val), 32'd0);
    check({tag, "_rdy_back"}, 32'(req_rdy), 32'd1);
    $display("op %s fn=%0d a=%08h b=%08h result=%08h expected=%08h lat=%0d",
             tag, fn, a, b, held, exp, lat);
  endtask

  task automatic expect_silence(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (resp_val) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int lat;
    logic [2:0]  fn;
    logic [31:0] a, b;
    reset = 1'b0; domain = 1'b0; req_val = 1'b0; req_fn = '0;
    req_a = '0; req_b = '0; kill = 1'b0; resp_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_rdy", 32'(req_rdy), 32'd1);
    check("rst_resp_val", 32'(resp_val), 32'd0);
    check("rst_result", resp_result, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Asynchronous reset in the middle of a multiply
    start_op(3'd0, 32'd9, 32'd11);
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("amid_req_rdy", 32'(req_rdy), 32'd1);
    check("amid_resp_val", 32'(resp_val), 32'd0);
    check("amid_result", resp_result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    expect_silence("amid_no_resp", 40);
    $display("op reset_mid_calc done");

    run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op("div_m7_2", 3'd1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("rem_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("divu_big", 3'd2, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 0);
    run_op("remu_big", 3'd4, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 0);
    run_op("div_by0", 3'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("rem_by0", 3'd3, 32'd5, 32'd0, 32'd5, 0);
    run_op("divm_by0", 3'd1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("remm_by0", 3'd3, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0);
    run_op("div_ovf", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    run_op("illegal", 3'd6, 32'd123, 32'd45, 32'd0, 0);
    run_op("backpress", 3'd1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 5);

    // Kill at cycle 20 of CALC, then a fresh multiply must be correct
    start_op(3'd0, 32'd1234, 32'd5678);
    repeat (19) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_rdy", 32'(req_rdy), 32'd1);
    expect_silence("kill_no_resp", 40);
    $display("op kill_mid_calc done");
    run_op("mul_3_4", 3'd0, 32'd3, 32'd4, 32'd12, 0);

    // Kill together with resp_rdy in DONE discards the response
    start_op(3'd2, 32'd77, 32'd7);
    wait_resp(lat);
    check("kd_lat", 32'(lat), 32'd33);
    kill = 1'b1; resp_rdy = 1'b1;
    @(negedge clk);
    kill = 1'b0; resp_rdy = 1'b0;
    check("kd_val_drop", 32'(resp_val), 32'd0);
    expect_silence("kd_no_resp", 5);
    $display("op kill_in_done done");

    // Kill while idle does not block the request accepted in that cycle
    kill = 1'b1;
    run_op("kill_idle", 3'd4, 32'd100, 32'd7, 32'd2, 0);

    for (int i = 0; i < 24; i++) begin
      fn = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), fn, a, b, ref_model(fn, a, b), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
